l15_refill_data_packer: RTL and testbench
=========================================

# l15_refill_data_packer

Refill write stage for the L1.5 instruction cache data bank. It accepts a cache-line refill from the L2 side as a stream of narrow beats and packs them into full data-bank words. It issues those words as write requests to the single-port data RAM and shares that port with lookup reads from the hit path. It sits directly upstream of the data RAM and drives its req/write/addr/wdata/be inputs.

## Interface
- DATA_WIDTH, 64: data-bank word width; must be a multiple of BEAT_WIDTH.
- ADDR_WIDTH, 7: data-bank word address width.
- BEAT_WIDTH, 32: refill beat width; BPW = DATA_WIDTH/BEAT_WIDTH beats per word (2).
- LINE_WORDS, 4: words per cache line, power of two; line index width LW = ADDR_WIDTH - log2(LINE_WORDS) (5).

Ports:
- clk  in  1  clock; the one clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- refill_start_i  in  1  begin line refill.
- refill_line_i  in  LW  target line index, sampled with start.
- start_ready_o  out  1  high in IDLE only.
- beat_valid_i  in  1  beat valid.
- beat_data_i  in  BEAT_WIDTH  beat payload.
- beat_last_i  in  1  sender's last-beat marker (checked only).
- beat_ready_o  out  1  beat accepted when valid&ready.
- rd_req_i  in  1  lookup read request.
- rd_addr_i  in  ADDR_WIDTH  lookup read address.
- rd_gnt_o  out  1  read issued to RAM this cycle.
- ram_req_o  out  1  to data RAM req.
- ram_write_o  out  1  to data RAM write.
- ram_addr_o  out  ADDR_WIDTH  to data RAM addr.
- ram_wdata_o  out  DATA_WIDTH  to data RAM wdata.
- ram_be_o  out  DATA_WIDTH/8  to data RAM be.
- refill_done_o  out  1  one-cycle pulse, line fully written.
- refill_err_o  out  1  sticky beat_last mismatch, cleared on next accepted start.

## Operation
- States: IDLE, FILL, FLUSH.
- IDLE -> FILL on refill_start_i: latch line index; clear beat counter, word counter and err.
- FILL:
  - Each accepted beat goes into assembly register slot beat_cnt; beat 0 goes to bits [BEAT_WIDTH-1:0].
  - On beat BPW-1 the completed word moves into the hold register (hold_valid=1, hold_addr={line, word_cnt}).
  - beat_ready_o = FILL & ~(beat completes word & hold_valid & ~hold_write_this_cycle).
- Final beat of the line (word LINE_WORDS-1, beat BPW-1): FILL -> FLUSH.
  - err set if beat_last_i=0 on that beat, or if beat_last_i=1 on any earlier beat.
  - The beat count is authoritative; a premature beat_last does not end the refill.
- FLUSH -> IDLE when the hold word is written; refill_done_o pulses the following cycle.
- Port arbitration (combinational):
  - Write selected = hold_valid & (~rd_req_i, or always per Configuration).
  - Write: ram_req=1, write=1, addr=hold_addr, wdata=hold, be=all ones.
  - Otherwise: ram_req=rd_req_i, write=0, addr=rd_addr_i, be=0; rd_gnt_o=rd_req_i.
- refill_start_i outside IDLE is ignored.

## Timing
- Beat to RAM write: the earliest write is the same cycle the hold register loads +1; i.e. the first write of a line occurs the cycle after its BPW-th beat is accepted.
- Read grant is combinational and same cycle; the RAM returns data one cycle later.
- Full-rate refill, no reads: 8 beats over 8 cycles; last write at cycle 9; refill_done_o at cycle 10.
- Hold full while the next word completes: that word's last beat is stalled; beat_ready_o stays low until the hold write cycle, when it is accepted (simultaneous drain+fill).
- Reset values: start_ready_o=1; beat_ready_o=0; refill_done_o=0; refill_err_o=0; ram_write_o=0; ram_be_o=0; ram_req_o=rd_req_i; rd_gnt_o=rd_req_i.
- Reset mid-refill: all state discarded; a partial line may remain in RAM (tag invalidation is the controller's responsibility); no done pulse.

## Configuration
- HIER_ICACHE_REFILL_WR_PRIO_EN defined: a pending hold write always wins; rd_gnt_o=0 while hold_valid.
- Undefined: reads win; a continuous rd_req_i may stall the refill indefinitely.

## Test plan
- Line 5, beats 0x11111111..0x88888888 back-to-back, no reads:
  - Writes at addr 20..23 with wdata 0x2222222211111111 .. 0x8888888877777777 and be=0xFF.
  - Done at cycle 10; err=0.
- Same refill with rd_req_i=1, rd_addr_i=0x03 throughout, macro undefined:
  - No writes and rd_gnt_o=1 throughout.
  - After rd_req_i drops, the hold write happens, then FILL resumes and beat_ready_o stalls/releases exactly once.
- Same as above with the macro defined: rd_gnt_o=0 in every hold-write cycle; write order and timing match the first test.
- beat_last_i=1 on beat 3: all 8 beats still absorbed; refill_err_o=1 at done; cleared on the next start.
- Assert rst after beat 5: start_ready_o=1, beat_ready_o=0, ram_write_o=0 on the next edge; no done pulse; a following refill of line 0 completes normally.
- refill_start_i during FILL: ignored; line index unchanged.

Source files
------------

// File: rtl/l15_refill_data_packer.sv
`default_nettype none
// ============================================================================
// Module   : l15_refill_data_packer
// Brief    : Packs L2 refill beats into L1.5 I-cache data-bank words and
//            shares the single RAM port with lookup reads.
// Options  : HIER_ICACHE_REFILL_WR_PRIO_EN - a pending refill write always
//            beats lookup reads (default: reads win).
// Revision : 1.0 - initial release
// ============================================================================
module l15_refill_data_packer #(
    parameter  int DATA_WIDTH = 64,
    parameter  int ADDR_WIDTH = 7,
    parameter  int BEAT_WIDTH = 32,
    parameter  int LINE_WORDS = 4,
    localparam int C_WIDX     = $clog2(LINE_WORDS),
    localparam int C_LW       = ADDR_WIDTH - C_WIDX
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      refill_start_i,
    input  logic [C_LW-1:0]           refill_line_i,
    output logic                      start_ready_o,
    input  logic                      beat_valid_i,
    input  logic [BEAT_WIDTH-1:0]     beat_data_i,
    input  logic                      beat_last_i,
    output logic                      beat_ready_o,
    input  logic                      rd_req_i,
    input  logic [ADDR_WIDTH-1:0]     rd_addr_i,
    output logic                      rd_gnt_o,
    output logic                      ram_req_o,
    output logic                      ram_write_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    output logic                      refill_done_o,
    output logic                      refill_err_o
);

    localparam int C_BPW = DATA_WIDTH / BEAT_WIDTH;
    localparam int C_BCW = (C_BPW > 1) ? $clog2(C_BPW) : 1;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_FILL  = 2'd1;
    localparam logic [1:0] C_ST_FLUSH = 2'd2;

    localparam logic [C_BCW-1:0]  C_LAST_BEAT = C_BCW'(C_BPW - 1);
    localparam logic [C_WIDX-1:0] C_LAST_WORD = C_WIDX'(LINE_WORDS - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [C_LW-1:0]       r_line;
    logic [C_BCW-1:0]      r_beat_cnt;
    logic [C_WIDX-1:0]     r_word_cnt;
    logic [DATA_WIDTH-1:0] r_asm;
    logic [DATA_WIDTH-1:0] w_asm_nxt;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_valid;
    logic [ADDR_WIDTH-1:0] r_hold_addr;
    logic                  r_last_seen;
    logic                  r_err;
    logic                  r_done;

    logic w_write_sel;
    logic w_beat_completes;
    logic w_beat_ready;
    logic w_beat_acc;
    logic w_word_done;
    logic w_line_done;
    logic w_start_acc;

`ifdef HIER_ICACHE_REFILL_WR_PRIO_EN
    assign w_write_sel = r_hold_valid;
`else
    assign w_write_sel = r_hold_valid & ~rd_req_i;
`endif

    assign w_start_acc      = (r_state == C_ST_IDLE) & refill_start_i;
    assign w_beat_completes = (r_beat_cnt == C_LAST_BEAT);
    // A completing beat may only enter when the hold slot is free or drains now.
    assign w_beat_ready     = (r_state == C_ST_FILL) &
                              ~(w_beat_completes & r_hold_valid & ~w_write_sel);
    assign w_beat_acc       = beat_valid_i & w_beat_ready;
    assign w_word_done      = w_beat_acc & w_beat_completes;
    assign w_line_done      = w_word_done & (r_word_cnt == C_LAST_WORD);

    always_comb begin
        w_asm_nxt = r_asm;
        w_asm_nxt[int'(r_beat_cnt) * BEAT_WIDTH +: BEAT_WIDTH] = beat_data_i;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE:  if (refill_start_i) w_state_nxt = C_ST_FILL;
            C_ST_FILL:  if (w_line_done)    w_state_nxt = C_ST_FLUSH;
            C_ST_FLUSH: if (w_write_sel)    w_state_nxt = C_ST_IDLE;
            default:                        w_state_nxt = C_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line      <= '0;
            r_beat_cnt  <= '0;
            r_word_cnt  <= '0;
            r_asm       <= '0;
            r_last_seen <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == C_ST_FLUSH) & w_write_sel;
            if (w_start_acc) begin
                r_line      <= refill_line_i;
                r_beat_cnt  <= '0;
                r_word_cnt  <= '0;
                r_last_seen <= 1'b0;
                r_err       <= 1'b0;
            end else if (w_beat_acc) begin
                r_asm <= w_asm_nxt;
                if (w_beat_completes) begin
                    r_beat_cnt <= '0;
                    r_word_cnt <= r_word_cnt + 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
                // The beat count ends the line; beat_last is only cross-checked.
                if (w_line_done) begin
                    r_err <= ~beat_last_i | r_last_seen;
                end else if (beat_last_i) begin
                    r_last_seen <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_hold_addr  <= '0;
        end else if (w_word_done) begin
            r_hold       <= w_asm_nxt;
            r_hold_valid <= 1'b1;
            r_hold_addr  <= {r_line, r_word_cnt};
        end else if (w_write_sel) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign start_ready_o = (r_state == C_ST_IDLE);
    assign beat_ready_o  = w_beat_ready;
    assign rd_gnt_o      = rd_req_i & ~w_write_sel;
    assign ram_req_o     = w_write_sel | rd_req_i;
    assign ram_write_o   = w_write_sel;
    assign ram_addr_o    = w_write_sel ? r_hold_addr : rd_addr_i;
    assign ram_wdata_o   = r_hold;
    assign ram_be_o      = {(DATA_WIDTH/8){w_write_sel}};
    assign refill_done_o = r_done;
    assign refill_err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_l15_refill_data_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_l15_refill_data_packer
// Brief    : Randomized self-checking bench for l15_refill_data_packer using a
//            queue-based model of the expected RAM write stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l15_refill_data_packer;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 7;
    localparam int BEAT_WIDTH = 32;
    localparam int LINE_WORDS = 4;
    localparam int BPW        = DATA_WIDTH / BEAT_WIDTH;
    localparam int NBEATS     = BPW * LINE_WORDS;
    localparam int LW         = 5;
`ifdef HIER_ICACHE_REFILL_WR_PRIO_EN
    localparam bit WR_PRIO = 1'b1;
`else
    localparam bit WR_PRIO = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    refill_start_i;
    logic [LW-1:0]           refill_line_i;
    logic                    start_ready_o;
    logic                    beat_valid_i;
    logic [BEAT_WIDTH-1:0]   beat_data_i;
    logic                    beat_last_i;
    logic                    beat_ready_o;
    logic                    rd_req_i;
    logic [ADDR_WIDTH-1:0]   rd_addr_i;
    logic                    rd_gnt_o;
    logic                    ram_req_o;
    logic                    ram_write_o;
    logic [ADDR_WIDTH-1:0]   ram_addr_o;
    logic [DATA_WIDTH-1:0]   ram_wdata_o;
    logic [DATA_WIDTH/8-1:0] ram_be_o;
    logic                    refill_done_o;
    logic                    refill_err_o;

    l15_refill_data_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .refill_start_i (refill_start_i),
        .refill_line_i  (refill_line_i),
        .start_ready_o  (start_ready_o),
        .beat_valid_i   (beat_valid_i),
        .beat_data_i    (beat_data_i),
        .beat_last_i    (beat_last_i),
        .beat_ready_o   (beat_ready_o),
        .rd_req_i       (rd_req_i),
        .rd_addr_i      (rd_addr_i),
        .rd_gnt_o       (rd_gnt_o),
        .ram_req_o      (ram_req_o),
        .ram_write_o    (ram_write_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_be_o       (ram_be_o),
        .refill_done_o  (refill_done_o),
        .refill_err_o   (refill_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  done_pending = 1'b0;
    bit  exp_err      = 1'b0;
    int  done_cyc     = -1;
    int  first_wr_cyc = -1;
    int  n_stall_ep   = 0;
    bit  prev_stall   = 1'b0;
    bit  stall_now;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Port-level observer: every RAM write must match the head of the expected stream.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            done_pending = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            stall_now = beat_valid_i && !beat_ready_o && !start_ready_o;
            if (stall_now && !prev_stall) n_stall_ep++;
            prev_stall = stall_now;
            if (ram_write_o) begin
                check("wr_req", ram_req_o, 1);
                check("wr_be", ram_be_o, 8'hFF);
                check("wr_blocked_by_rd", rd_req_i && !WR_PRIO, 0);
                check("wr_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", ram_addr_o, mon_e.addr);
                    check("wr_data", ram_wdata_o, mon_e.data);
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                end
            end else begin
                check("rd_req_pass", ram_req_o, rd_req_i);
                check("rd_be_zero", ram_be_o, 0);
                if (rd_req_i) check("rd_addr_pass", ram_addr_o, rd_addr_i);
            end
            check("rd_gnt", rd_gnt_o, rd_req_i && !ram_write_o);
            if (refill_done_o) begin
                check("done_expected", done_pending, 1);
                check("done_all_written", exp_q.size(), 0);
                check("err_at_done", refill_err_o, exp_err);
                done_pending = 1'b0;
                done_cyc     = cyc;
            end
        end
    end

    // rd_mode: 0 no reads, 1 random reads, 2 reads held until the refill is blocked.
    task automatic refill(input int line, input bit pattern, input int last_pos,
                          input int gap_pct, input int rd_mode, input int rst_after,
                          input bit poke_start);
        logic [BEAT_WIDTH-1:0] beats[NBEATS];
        wr_t e;
        int  i, budget, stall_run, start_cyc;
        bit  acc;
        for (int b = 0; b < NBEATS; b++)
            beats[b] = pattern ? BEAT_WIDTH'((b + 1) * 32'h11111111) : $urandom();
        for (int w = 0; w < LINE_WORDS; w++) begin
            e.addr = ADDR_WIDTH'(line * LINE_WORDS + w);
            for (int b = 0; b < BPW; b++)
                e.data[b*BEAT_WIDTH +: BEAT_WIDTH] = beats[w*BPW + b];
            exp_q.push_back(e);
        end
        exp_err      = (last_pos != NBEATS - 1);
        first_wr_cyc = -1;
        n_stall_ep   = 0;
        check("start_ready_idle", start_ready_o, 1);
        refill_start_i = 1'b1;
        refill_line_i  = LW'(line);
        start_cyc      = cyc;
        done_pending   = 1'b1;
        @(posedge clk); #1;
        refill_start_i = 1'b0;
        check("start_ready_fill", start_ready_o, 0);
        check("err_cleared_on_start", refill_err_o, 0);
        i = 0; budget = 0; stall_run = 0;
        while (i < NBEATS && budget < 2000) begin
            budget++;
            beat_valid_i = ($urandom_range(99) >= gap_pct);
            beat_data_i  = beat_valid_i ? beats[i] : $urandom();
            beat_last_i  = beat_valid_i && (i == last_pos);
            case (rd_mode)
                1:       rd_req_i = ($urandom_range(99) < 40);
                2:       rd_req_i = (i < 4) && (stall_run < 3);
                default: rd_req_i = 1'b0;
            endcase
            rd_addr_i = (rd_mode == 2) ? 7'h03 : ADDR_WIDTH'($urandom());
            if (poke_start) begin
                refill_start_i = (i == 2);
                refill_line_i  = LW'(line) ^ 5'h1F;
            end
            @(negedge clk);
            acc = beat_valid_i && beat_ready_o;
            if (beat_valid_i && !beat_ready_o) stall_run++;
            @(posedge clk); #1;
            if (acc) i++;
            if (rst_after >= 0 && acc && i == rst_after + 1) break;
        end
        beat_valid_i = 1'b0; beat_last_i = 1'b0; rd_req_i = 1'b0; refill_start_i = 1'b0;
        check("beats_taken", i, (rst_after >= 0) ? rst_after + 1 : NBEATS);
        if (rd_mode == 2) check("stall_episodes", n_stall_ep, WR_PRIO ? 0 : 1);
        if (rd_mode == 0) check("no_stall", n_stall_ep, 0);
        if (rst_after >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_start_ready", start_ready_o, 1);
            check("rst_beat_ready", beat_ready_o, 0);
            check("rst_write", ram_write_o, 0);
            check("rst_done", refill_done_o, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (12) @(posedge clk);
            #1;
            check("rst_idle", start_ready_o, 1);
        end else begin
            for (int k = 0; k < 300 && done_pending; k++) @(posedge clk);
            #1;
            check("done_seen", done_pending, 0);
            if (gap_pct == 0 && rd_mode == 0) begin
                check("done_cycle", done_cyc - start_cyc, 10);
                check("first_wr_cycle", first_wr_cyc - start_cyc, 3);
            end
            check("err_sticky", refill_err_o, exp_err);
            check("done_one_cycle", refill_done_o, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; refill_start_i = 1'b0; refill_line_i = '0;
        beat_valid_i = 1'b0; beat_data_i = '0; beat_last_i = 1'b0;
        rd_req_i = 1'b1; rd_addr_i = 7'h05;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_start_ready", start_ready_o, 1);
        check("reset_beat_ready", beat_ready_o, 0);
        check("reset_done", refill_done_o, 0);
        check("reset_err", refill_err_o, 0);
        check("reset_write", ram_write_o, 0);
        check("reset_be", ram_be_o, 0);
        check("reset_ram_req", ram_req_o, 1);
        check("reset_rd_gnt", rd_gnt_o, 1);
        @(posedge clk); #1;
        rst = 1'b0; rd_req_i = 1'b0;
        @(posedge clk); #1;

        refill(5, 1'b1, NBEATS - 1, 0, 0, -1, 1'b0);
        refill(5, 1'b1, NBEATS - 1, 0, 2, -1, 1'b0);
        refill(9, 1'b0, 3, 0, 0, -1, 1'b0);
        refill(12, 1'b0, NBEATS - 1, 0, 0, -1, 1'b0);
        refill(2, 1'b0, NBEATS - 1, 0, 0, 5, 1'b0);
        refill(0, 1'b1, NBEATS - 1, 0, 0, -1, 1'b0);
        refill(7, 1'b0, NBEATS - 1, 0, 0, -1, 1'b1);
        for (int t = 0; t < 20; t++)
            refill(int'($urandom_range(31)), 1'b0,
                   ($urandom_range(3) == 0) ? int'($urandom_range(NBEATS - 2)) : NBEATS - 1,
                   30, 1, -1, 1'b0);
        refill(31, 1'b0, NBEATS - 1, 0, 0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
